gray_sync_rx: RTL and testbench



---
 rtl/gray_sync_rx.sv | 117 +++++++++++
 tb/tb_gray_sync_rx.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_sync_rx.sv
// Destination-domain receiver for gray-coded multi-bit values: per-bit synchronizer chain,
// gray-to-binary decode, change/delta reporting and a sticky multi-bit-flip error flag.
module gray_sync_rx #(
  parameter int WIDTH          = 8,
  parameter int NUM_CH         = 1,
  parameter int SYNC_STAGES    = 2,
  parameter int REG_OUTPUT     = 0,
  parameter int CHECK_LOSSLESS = 1
) (
  input  logic                     dest_clk,
  input  logic                     dest_rst_n,
  input  logic [NUM_CH*WIDTH-1:0]  src_in_gray,
  input  logic                     err_clr,
  output logic [NUM_CH*WIDTH-1:0]  dest_out_gray,
  output logic [NUM_CH*WIDTH-1:0]  dest_out_bin,
  output logic [NUM_CH-1:0]        dest_update,
  output logic [NUM_CH*WIDTH-1:0]  dest_delta,
  output logic [NUM_CH-1:0]        err_multi_bit
);

  localparam int TOT_W = NUM_CH * WIDTH;
  localparam int CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] PRIME_MAX = CNT_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][TOT_W-1:0] sync_q;
  logic [TOT_W-1:0]                  cur;
  logic [TOT_W-1:0]                  prev_q;
  logic [CNT_W-1:0]                  prime_cnt;
  logic                              primed;
  logic [NUM_CH-1:0]                 err_q;

  logic [TOT_W-1:0]  bin_c;
  logic [TOT_W-1:0]  delta_c;
  logic [NUM_CH-1:0] upd_c;
  logic [NUM_CH-1:0] viol_c;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // NOTE: the sync chain is a handful of discrete flops, not a RAM, so it is reset like any
  // other state; src_in_gray feeds sync_q[0] directly with no logic in front of it.
  always_ff @(posedge dest_clk or negedge dest_rst_n) begin
    if (!dest_rst_n) begin
      sync_q    <= '0;
      prev_q    <= '0;
      prime_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the old value of its
      // predecessor, which is what makes this a shift chain rather than a wire.
      sync_q <= {sync_q[SYNC_STAGES-2:0], src_in_gray};
      prev_q <= cur;
      if (prime_cnt != PRIME_MAX) prime_cnt <= prime_cnt + 1'b1;
    end
  end

  assign cur    = sync_q[SYNC_STAGES-1];
  assign primed = (prime_cnt == PRIME_MAX);

  always_comb begin
    logic [WIDTH-1:0] cur_bin;
    logic [WIDTH-1:0] prev_bin;
    logic [WIDTH-1:0] flips;
    // NOTE: every comb output and local gets a default first so no path can infer a latch.
    bin_c    = '0;
    delta_c  = '0;
    upd_c    = '0;
    viol_c   = '0;
    cur_bin  = '0;
    prev_bin = '0;
    flips    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cur_bin  = gray2bin(cur[c*WIDTH +: WIDTH]);
      prev_bin = gray2bin(prev_q[c*WIDTH +: WIDTH]);
      flips    = cur[c*WIDTH +: WIDTH] ^ prev_q[c*WIDTH +: WIDTH];
      bin_c[c*WIDTH +: WIDTH] = cur_bin;
      upd_c[c] = primed && (flips != '0);
      if (upd_c[c]) delta_c[c*WIDTH +: WIDTH] = cur_bin - prev_bin;
      // More than one bit set <=> clearing the lowest set bit leaves something behind.
      viol_c[c] = (CHECK_LOSSLESS != 0) && primed && ((flips & (flips - 1'b1)) != '0);
    end
  end

  // A new violation outranks a simultaneous clear so no error is ever lost.
  always_ff @(posedge dest_clk or negedge dest_rst_n) begin
    if (!dest_rst_n) err_q <= '0;
    else             err_q <= viol_c | (err_clr ? '0 : err_q);
  end

  if (REG_OUTPUT != 0) begin : g_out_reg
    always_ff @(posedge dest_clk or negedge dest_rst_n) begin
      if (!dest_rst_n) begin
        dest_out_gray <= '0;
        dest_out_bin  <= '0;
        dest_update   <= '0;
        dest_delta    <= '0;
        err_multi_bit <= '0;
      end else begin
        dest_out_gray <= cur;
        dest_out_bin  <= bin_c;
        dest_update   <= upd_c;
        dest_delta    <= delta_c;
        err_multi_bit <= err_q;
      end
    end
  end else begin : g_out_comb
    assign dest_out_gray = cur;
    assign dest_out_bin  = bin_c;
    assign dest_update   = upd_c;
    assign dest_delta    = delta_c;
    assign err_multi_bit = err_q;
  end

endmodule

// File: tb/tb_gray_sync_rx.sv
// Directed bench for gray_sync_rx: instance A uses the defaults (1 ch, 2 stages, comb outputs),
// instance B uses 2 channels, 3 stages and registered outputs.
module tb_gray_sync_rx;

  logic        dest_clk;
  logic        dest_rst_n;
  logic [7:0]  src_a;
  logic        err_clr_a;
  logic [7:0]  gray_a, bin_a, delta_a;
  logic        upd_a, err_a;
  logic [15:0] src_b;
  logic        err_clr_b;
  logic [15:0] gray_b, bin_b, delta_b;
  logic [1:0]  upd_b, err_b;

  int errors = 0;
  int checks = 0;

  gray_sync_rx #(
    .WIDTH(8), .NUM_CH(1), .SYNC_STAGES(2), .REG_OUTPUT(0), .CHECK_LOSSLESS(1)
  ) u_dut_a (
    .dest_clk      (dest_clk),
    .dest_rst_n    (dest_rst_n),
    .src_in_gray   (src_a),
    .err_clr       (err_clr_a),
    .dest_out_gray (gray_a),
    .dest_out_bin  (bin_a),
    .dest_update   (upd_a),
    .dest_delta    (delta_a),
    .err_multi_bit (err_a)
  );

  gray_sync_rx #(
    .WIDTH(8), .NUM_CH(2), .SYNC_STAGES(3), .REG_OUTPUT(1), .CHECK_LOSSLESS(1)
  ) u_dut_b (
    .dest_clk      (dest_clk),
    .dest_rst_n    (dest_rst_n),
    .src_in_gray   (src_b),
    .err_clr       (err_clr_b),
    .dest_out_gray (gray_b),
    .dest_out_bin  (bin_b),
    .dest_update   (upd_b),
    .dest_delta    (delta_b),
    .err_multi_bit (err_b)
  );

  initial dest_clk = 1'b0;
  always #5 dest_clk = ~dest_clk;

  task automatic tick();
    @(posedge dest_clk);
    #1;
  endtask

  task automatic check_a_zero(input string name);
    checks++;
    if (gray_a !== 8'h00 || bin_a !== 8'h00 || upd_a !== 1'b0 || delta_a !== 8'h00 || err_a !== 1'b0)
      $display("FAIL %s: A got gray=%h bin=%h upd=%b delta=%h err=%b, expected all 0",
               name, gray_a, bin_a, upd_a, delta_a, err_a);
    if (gray_a !== 8'h00 || bin_a !== 8'h00 || upd_a !== 1'b0 || delta_a !== 8'h00 || err_a !== 1'b0)
      errors++;
    checks++;
    if (gray_b !== 16'h0 || bin_b !== 16'h0 || upd_b !== 2'b0 || delta_b !== 16'h0 || err_b !== 2'b0) begin
      errors++;
      $display("FAIL %s: B got gray=%h bin=%h upd=%b delta=%h err=%b, expected all 0",
               name, gray_b, bin_b, upd_b, delta_b, err_b);
    end
  endtask

  task automatic test_reset();
    dest_rst_n = 1'b0;
    src_a      = 8'h00;
    src_b      = 16'h0200;
    err_clr_a  = 1'b0;
    err_clr_b  = 1'b0;
    #1;
    check_a_zero("reset_async");
    repeat (3) tick();
    check_a_zero("reset_held");
    dest_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (gray_a !== 8'h00 || bin_a !== 8'h00 || upd_a !== 1'b0 || delta_a !== 8'h00 || err_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: got gray=%h bin=%h upd=%b delta=%h err=%b, expected all 0",
                 i, gray_a, bin_a, upd_a, delta_a, err_a);
      end
      checks++;
      if (upd_b !== 2'b00 || err_b !== 2'b00) begin
        errors++;
        $display("FAIL reset_idle_b cyc%0d: got upd=%b err=%b, expected 00 00", i, upd_b, err_b);
      end
    end
    checks++;
    if (bin_b !== 16'h0300 || gray_b !== 16'h0200) begin
      errors++;
      $display("FAIL reset_b_value: got gray=%h bin=%h, expected 0200 0300", gray_b, bin_b);
    end
  endtask

  task automatic test_step();
    src_a = 8'h01;
    repeat (3) tick();
    src_a = 8'h03;
    repeat (3) tick();
    checks++;
    if (bin_a !== 8'd2 || err_a !== 1'b0 || upd_a !== 1'b0) begin
      errors++;
      $display("FAIL step_walk: got bin=%0d err=%b upd=%b, expected 2 0 0", bin_a, err_a, upd_a);
    end
    src_a = 8'h02;
    tick();
    checks++;
    if (bin_a !== 8'd2 || upd_a !== 1'b0) begin
      errors++;
      $display("FAIL step_capture: got bin=%0d upd=%b, expected 2 0", bin_a, upd_a);
    end
    tick();
    checks++;
    if (gray_a !== 8'h02 || bin_a !== 8'd3 || upd_a !== 1'b1 || delta_a !== 8'h01) begin
      errors++;
      $display("FAIL step_out: got gray=%h bin=%0d upd=%b delta=%h, expected 02 3 1 01",
               gray_a, bin_a, upd_a, delta_a);
    end
    tick();
    checks++;
    if (bin_a !== 8'd3 || upd_a !== 1'b0 || delta_a !== 8'h00 || err_a !== 1'b0) begin
      errors++;
      $display("FAIL step_after: got bin=%0d upd=%b delta=%h err=%b, expected 3 0 00 0",
               bin_a, upd_a, delta_a, err_a);
    end
  endtask

  task automatic test_violation();
    src_a = 8'h00;
    repeat (4) tick();
    checks++;
    if (bin_a !== 8'd0 || err_a !== 1'b0) begin
      errors++;
      $display("FAIL viol_setup: got bin=%0d err=%b, expected 0 0", bin_a, err_a);
    end
    src_a = 8'h03;
    tick();
    checks++;
    if (upd_a !== 1'b0) begin
      errors++;
      $display("FAIL viol_early: got upd=%b, expected 0", upd_a);
    end
    tick();
    checks++;
    if (upd_a !== 1'b1 || delta_a !== 8'h02 || err_a !== 1'b0) begin
      errors++;
      $display("FAIL viol_delta: got upd=%b delta=%h err=%b, expected 1 02 0", upd_a, delta_a, err_a);
    end
    tick();
    checks++;
    if (err_a !== 1'b1 || upd_a !== 1'b0) begin
      errors++;
      $display("FAIL viol_set: got err=%b upd=%b, expected 1 0", err_a, upd_a);
    end
    repeat (3) tick();
    checks++;
    if (err_a !== 1'b1) begin
      errors++;
      $display("FAIL viol_sticky: got err=%b, expected 1", err_a);
    end
    err_clr_a = 1'b1;
    tick();
    err_clr_a = 1'b0;
    checks++;
    if (err_a !== 1'b0) begin
      errors++;
      $display("FAIL err_clr: got err=%b, expected 0", err_a);
    end
    src_a = 8'h00;
    tick();
    tick();
    checks++;
    if (upd_a !== 1'b1 || delta_a !== 8'hFE) begin
      errors++;
      $display("FAIL viol2_delta: got upd=%b delta=%h, expected 1 fe", upd_a, delta_a);
    end
    err_clr_a = 1'b1;
    tick();
    err_clr_a = 1'b0;
    checks++;
    if (err_a !== 1'b1) begin
      errors++;
      $display("FAIL viol_beats_clr: got err=%b, expected 1", err_a);
    end
    tick();
    checks++;
    if (err_a !== 1'b1) begin
      errors++;
      $display("FAIL viol_beats_clr_hold: got err=%b, expected 1", err_a);
    end
  endtask

  // Reset asserted mid-cycle with the source already switched to a new held value.
  task automatic reset_with(input logic [7:0] v, input string name);
    dest_rst_n = 1'b0;
    src_a      = v;
    #1;
    check_a_zero(name);
    tick();
    tick();
    dest_rst_n = 1'b1;
  endtask

  task automatic test_reset_nonzero();
    reset_with(8'h56, "reset_mid");
    tick();
    checks++;
    if (bin_a !== 8'd0 || upd_a !== 1'b0) begin
      errors++;
      $display("FAIL nz_fill1: got bin=%0d upd=%b, expected 0 0", bin_a, upd_a);
    end
    tick();
    checks++;
    if (gray_a !== 8'h56 || bin_a !== 8'd100 || upd_a !== 1'b0) begin
      errors++;
      $display("FAIL nz_fill2: got gray=%h bin=%0d upd=%b, expected 56 100 0", gray_a, bin_a, upd_a);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bin_a !== 8'd100 || upd_a !== 1'b0 || err_a !== 1'b0 || delta_a !== 8'h00) begin
        errors++;
        $display("FAIL nz_hold cyc%0d: got bin=%0d upd=%b err=%b delta=%h, expected 100 0 0 00",
                 i, bin_a, upd_a, err_a, delta_a);
      end
    end
  endtask

  task automatic test_wrap();
    reset_with(8'h80, "reset_wrap");
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (upd_a !== 1'b0 || err_a !== 1'b0) begin
        errors++;
        $display("FAIL wrap_prime cyc%0d: got upd=%b err=%b, expected 0 0", i, upd_a, err_a);
      end
    end
    checks++;
    if (bin_a !== 8'd255) begin
      errors++;
      $display("FAIL wrap_start: got bin=%0d, expected 255", bin_a);
    end
    src_a = 8'h00;
    tick();
    tick();
    checks++;
    if (bin_a !== 8'd0 || upd_a !== 1'b1 || delta_a !== 8'h01 || err_a !== 1'b0) begin
      errors++;
      $display("FAIL wrap_out: got bin=%0d upd=%b delta=%h err=%b, expected 0 1 01 0",
               bin_a, upd_a, delta_a, err_a);
    end
    tick();
    checks++;
    if (err_a !== 1'b0 || upd_a !== 1'b0) begin
      errors++;
      $display("FAIL wrap_err: got err=%b upd=%b, expected 0 0", err_a, upd_a);
    end
  endtask

  task automatic test_multi_ch();
    src_b[7:0] = 8'h01;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (upd_b !== 2'b00 || bin_b !== 16'h0300) begin
        errors++;
        $display("FAIL mc_wait cyc%0d: got upd=%b bin=%h, expected 00 0300", i, upd_b, bin_b);
      end
    end
    tick();
    checks++;
    if (upd_b !== 2'b01 || delta_b !== 16'h0001 || bin_b !== 16'h0301 || gray_b !== 16'h0201) begin
      errors++;
      $display("FAIL mc_update: got upd=%b delta=%h bin=%h gray=%h, expected 01 0001 0301 0201",
               upd_b, delta_b, bin_b, gray_b);
    end
    tick();
    checks++;
    if (upd_b !== 2'b00 || delta_b !== 16'h0000 || err_b !== 2'b00) begin
      errors++;
      $display("FAIL mc_after: got upd=%b delta=%h err=%b, expected 00 0000 00", upd_b, delta_b, err_b);
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_violation();
    test_reset_nonzero();
    test_wrap();
    test_multi_ch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
